// File: rtl/wb_vector_checker_pkg.sv
// Shared state encoding and default parameters for the Wishbone vector checker.
// Optional build: WBVC_STOP_ON_ERR_EN stops a run at the first mismatch.
package wb_vector_checker_pkg;

    localparam int          DEF_DATA_W  = 32;
    localparam int          DEF_RES_W   = 16;
    localparam int          DEF_NUM_VEC = 100;
    localparam int          DEF_TIMEOUT = 1024;
    localparam logic [31:0] DEF_TGT_ADR = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbvc_timeout_cnt.sv
// Per-transfer watchdog: counts enabled cycles since the last clear.
// expired is raised on the TIMEOUT-th enabled cycle.
module wbvc_timeout_cnt
    import wb_vector_checker_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = clog2_min1(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_vector_checker.sv
// Wishbone master that writes each operand, reads the result back and compares it.
// Define WBVC_STOP_ON_ERR_EN to end the run at the first mismatching vector.
module wb_vector_checker
    import wb_vector_checker_pkg::*;
#(
    parameter int          DATA_W  = DEF_DATA_W,
    parameter int          RES_W   = DEF_RES_W,
    parameter int          NUM_VEC = DEF_NUM_VEC,
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter logic [31:0] TGT_ADR = DEF_TGT_ADR,
    localparam int         ADDR_W  = clog2_min1(NUM_VEC)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    start_i,
    output logic [ADDR_W-1:0]       vec_addr_o,
    input  logic [RES_W+DATA_W-1:0] vec_data_i,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_W/8-1:0]     wbm_sel_o,
    output logic [31:0]             wbm_adr_o,
    output logic [DATA_W-1:0]       wbm_dat_o,
    input  logic [DATA_W-1:0]       wbm_dat_i,
    input  logic                    wbm_ack_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [ADDR_W:0]         err_cnt_o
);

`ifdef WBVC_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   err_q;
    logic [RES_W-1:0]  rd_q;
    logic              to_q;
    logic              stb, ack, expired;
    logic              mismatch, last, go;
    logic              unused_dat;

    assign stb      = (state_q == ST_WR) || (state_q == ST_RD);
    assign ack      = stb && wbm_ack_i;
    assign mismatch = rd_q != vec_data_i[RES_W+DATA_W-1:DATA_W];
    assign last     = addr_q == ADDR_W'(NUM_VEC - 1);
    assign go       = start_i &&
                      ((state_q == ST_IDLE) || (state_q == ST_FIN));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                if (go) state_d = ST_WR;
            end
            ST_WR: begin
                if (ack)          state_d = ST_RD;
                else if (expired) state_d = ST_FIN;
            end
            ST_RD: begin
                if (ack)          state_d = ST_CHECK;
                else if (expired) state_d = ST_FIN;
            end
            ST_CHECK: begin
                if (last || (STOP_ON_ERR && mismatch))
                    state_d = ST_FIN;
                else
                    state_d = ST_WR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change re-arms the watchdog for the next transfer.
    wbvc_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clear  (state_q != state_d),
        .enable (stb),
        .expired(expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            err_q   <= '0;
            rd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                addr_q <= '0;
                err_q  <= '0;
                to_q   <= 1'b0;
            end
            if ((state_q == ST_RD) && ack)
                rd_q <= wbm_dat_i[RES_W-1:0];
            if (stb && !ack && expired)
                to_q <= 1'b1;
            if (state_q == ST_CHECK) begin
                if (mismatch)
                    err_q <= err_q + 1'b1;
                if (state_d == ST_WR)
                    addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign wbm_cyc_o  = stb;
    assign wbm_stb_o  = stb;
    assign wbm_we_o   = state_q == ST_WR;
    assign wbm_sel_o  = '1;
    assign wbm_adr_o  = TGT_ADR;
    assign wbm_dat_o  = (state_q == ST_WR) ? vec_data_i[DATA_W-1:0] : '0;
    assign busy_o     = stb || (state_q == ST_CHECK);
    assign done_o     = state_q == ST_FIN;
    assign pass_o     = done_o && (err_q == '0) && !to_q;
    assign timeout_o  = to_q;
    assign err_cnt_o  = err_q;
    assign vec_addr_o = addr_q;
    assign unused_dat = ^wbm_dat_i;

endmodule

// File: tb/tb_wb_vector_checker.sv
// Bench for wb_vector_checker: GCD slave, table runs, random runs, corner cases.
// Expectations follow the WBVC_STOP_ON_ERR_EN setting of the build.
module tb_wb_vector_checker;

    localparam int          DW  = 32;
    localparam int          RW  = 16;
    localparam int          NV  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] TGT = 32'h0000_1000;

`ifdef WBVC_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     vec_addr;
    logic [RW+DW-1:0] vec_data;
    logic           cyc, stb, we, ack;
    logic [3:0]     sel;
    logic [31:0]    adr;
    logic [DW-1:0]  dat_o, dat_i;
    logic           busy, done, pass, tmo;
    logic [2:0]     err;

    logic [RW+DW-1:0] vmem [NV];

    assign vec_data = vmem[vec_addr];

    always #5 clk = ~clk;

    wb_vector_checker #(
        .DATA_W (DW),
        .RES_W  (RW),
        .NUM_VEC(NV),
        .TIMEOUT(TO),
        .TGT_ADR(TGT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .start_i   (start),
        .vec_addr_o(vec_addr),
        .vec_data_i(vec_data),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack),
        .busy_o    (busy),
        .done_o    (done),
        .pass_o    (pass),
        .timeout_o (tmo),
        .err_cnt_o (err)
    );

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD slave: a write latches {a,b}, a read returns gcd(a,b).
    bit          never_ack = 1'b0;
    bit          rand_lat  = 1'b0;
    int          fix_lat   = 0;
    int          rnd_lat;
    int          wait_cnt;
    int          wr_count;
    logic [DW-1:0] wr_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            wait_cnt <= 0;
            rnd_lat  <= 0;
            wr_count <= 0;
            wr_reg   <= '0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && !never_ack) begin
                if (wait_cnt >= (rand_lat ? rnd_lat : fix_lat)) begin
                    ack      <= 1'b1;
                    wait_cnt <= 0;
                    rnd_lat  <= int'($urandom_range(0, 3));
                    if (we) begin
                        wr_reg   <= dat_o;
                        wr_count <= wr_count + 1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    assign dat_i = DW'(gcd(int'(wr_reg[31:16]), int'(wr_reg[15:0])));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int a [4];
        int b [4];
        int e [4];
        int err;
        int addr;
        int wr;
    } vrec_t;

    vrec_t tbl [5];

    task automatic load(input int a [4], input int b [4], input int e [4]);
        for (int k = 0; k < NV; k++)
            vmem[k] = {RW'(e[k]), 16'(a[k]), 16'(b[k])};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("run_done", done, 1);
    endtask

    task automatic run_checks(input string tag, input int exp_err,
                              input int exp_addr, input int exp_wr,
                              input int base);
        check({tag, "_err"},  err, exp_err);
        check({tag, "_pass"}, pass, exp_err == 0);
        check({tag, "_addr"}, vec_addr, exp_addr);
        check({tag, "_wr"},   wr_count - base, exp_wr);
        check({tag, "_tmo"},  tmo, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles, base, hi, found;

        tbl[0] = '{'{48, 7, 12, 100}, '{18, 5, 18, 75}, '{6, 1, 6, 25},
                   0, 3, 4};
        tbl[1] = '{'{48, 7, 12, 100}, '{18, 5, 18, 75}, '{6, 1, 5, 25},
                   1, STOP ? 2 : 3, STOP ? 3 : 4};
        tbl[2] = '{'{48, 7, 12, 100}, '{18, 5, 18, 75}, '{7, 1, 6, 24},
                   STOP ? 1 : 2, STOP ? 0 : 3, STOP ? 1 : 4};
        tbl[3] = '{'{9, 21, 64, 17}, '{6, 14, 40, 51}, '{3, 7, 8, 17},
                   0, 3, 4};
        tbl[4] = '{'{9, 21, 64, 17}, '{6, 14, 40, 51}, '{0, 0, 0, 0},
                   STOP ? 1 : 4, STOP ? 0 : 3, STOP ? 1 : 4};

        load(tbl[0].a, tbl[0].b, tbl[0].e);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, pass, tmo}, 4'b0000);
        check("rst_strobes", {cyc, stb, we}, 3'b000);
        check("rst_err", err, 0);
        check("rst_addr", vec_addr, 0);

        for (int i = 0; i < 5; i++) begin
            load(tbl[i].a, tbl[i].b, tbl[i].e);
            base = wr_count;
            pulse_start();
            wait_done(200, cycles);
            if (i == 0)
                check("latency_20", cycles, 20);
            run_checks($sformatf("tbl%0d", i), tbl[i].err,
                       tbl[i].addr, tbl[i].wr, base);
        end

        // Restart from FIN after a failing run.
        load(tbl[1].a, tbl[1].b, tbl[1].e);
        pulse_start();
        wait_done(200, cycles);
        pulse_start();
        check("restart_addr", vec_addr, 0);
        check("restart_err", err, 0);
        check("restart_stat", {busy, done, pass}, 3'b100);
        wait_done(200, cycles);
        check("restart_final_err", err, 1);

        // start while busy is ignored.
        load(tbl[0].a, tbl[0].b, tbl[0].e);
        base = wr_count;
        pulse_start();
        repeat (6) @(negedge clk);
        check("busy_before", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_start_addr", vec_addr, 1);
        check("busy_start_err", err, 0);
        wait_done(200, cycles);
        check("busy_start_len", cycles + 8, 20);
        run_checks("busy_run", 0, 3, 4, base);

        // Slave never acknowledges.
        never_ack = 1'b1;
        pulse_start();
        check("wr_sel", sel, 4'hf);
        check("wr_adr", adr, TGT);
        check("wr_we", we, 1);
        check("wr_dat", dat_o, {16'd48, 16'd18});
        hi = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (cyc) hi++;
            @(negedge clk);
        end
        check("tmo_cycles", hi, TO);
        check("tmo_flag", tmo, 1);
        check("tmo_stat", {done, pass, busy}, 3'b100);
        check("tmo_strobes", {cyc, stb}, 2'b00);
        never_ack = 1'b0;

        // Async reset in RD of vector 2 with an ack outstanding.
        fix_lat = 3;
        pulse_start();
        check("tmo_cleared", tmo, 0);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (cyc && !we && vec_addr == 2) found = 1;
            else @(negedge clk);
        end
        check("rd2_reached", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_strobes", {cyc, stb}, 2'b00);
        check("arst_status", {busy, done, pass, tmo}, 4'b0000);
        check("arst_addr", vec_addr, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_autostart", {busy, cyc, done}, 3'b000);
        fix_lat = 0;

        // Random vectors, random ack latency.
        rand_lat = 1'b1;
        for (int it = 0; it < 20; it++) begin
            int a [4];
            int b [4];
            int e [4];
            int n_err, first_bad, g;
            n_err = 0;
            first_bad = -1;
            for (int k = 0; k < NV; k++) begin
                a[k] = int'($urandom_range(1, 600));
                b[k] = int'($urandom_range(1, 600));
                g = gcd(a[k], b[k]);
                e[k] = ($urandom_range(0, 3) == 0) ?
                       g + int'($urandom_range(1, 9)) : g;
                if (e[k] != g) begin
                    n_err++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            load(a, b, e);
            base = wr_count;
            pulse_start();
            wait_done(300, cycles);
            if (STOP && first_bad >= 0)
                run_checks($sformatf("rnd%0d", it), 1, first_bad,
                           first_bad + 1, base);
            else
                run_checks($sformatf("rnd%0d", it), n_err, 3, 4, base);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
